// File: rtl/fch_arb.sv
// Two-master instruction-fetch arbiter: round-robin grant held while the slave stalls,
// with an outstanding-ID FIFO that steers in-order slave responses back to the requester.
module fch_arb #(
    parameter int PC_W     = 32,
    parameter int IR_W     = 32,
    parameter int OT_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_req_vld,
    output logic            m0_req_rdy,
    input  logic [PC_W-1:0] m0_req_pc,
    output logic            m0_rsp_vld,
    input  logic            m0_rsp_rdy,
    output logic [IR_W-1:0] m0_rsp_ir,

    input  logic            m1_req_vld,
    output logic            m1_req_rdy,
    input  logic [PC_W-1:0] m1_req_pc,
    output logic            m1_rsp_vld,
    input  logic            m1_rsp_rdy,
    output logic [IR_W-1:0] m1_rsp_ir,

    output logic            s_req_vld,
    input  logic            s_req_rdy,
    output logic [PC_W-1:0] s_req_pc,
    input  logic            s_rsp_vld,
    output logic            s_rsp_rdy,
    input  logic [IR_W-1:0] s_rsp_ir,

    output logic            idle
);

    localparam int CNT_W = $clog2(OT_DEPTH + 1);
    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OT_DEPTH - 1);

    logic                rr_last;
    logic                lock;
    logic                lock_id;
    logic [OT_DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    ot_cnt;

    logic gnt;
    logic full;
    logic empty;
    logic head;
    logic head_rdy;
    logic req_hsk;
    logic rsp_hsk;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A stalled request keeps its grant so the slave sees a stable address.
    always_comb begin
        gnt = 1'b0;
        if (lock) begin
            gnt = lock_id;
        end else if (m0_req_vld && m1_req_vld) begin
            gnt = ~rr_last;
        end else if (m1_req_vld) begin
            gnt = 1'b1;
        end
    end

    assign full  = (ot_cnt == CNT_FULL);
    assign empty = (ot_cnt == '0);

    assign s_req_vld  = (m0_req_vld | m1_req_vld) & ~full;
    assign s_req_pc   = gnt ? m1_req_pc : m0_req_pc;
    assign m0_req_rdy = ~gnt & s_req_rdy & ~full & m0_req_vld;
    assign m1_req_rdy =  gnt & s_req_rdy & ~full & m1_req_vld;
    assign req_hsk    = s_req_vld & s_req_rdy;

    assign head       = id_fifo[rd_ptr];
    assign head_rdy   = head ? m1_rsp_rdy : m0_rsp_rdy;
    assign s_rsp_rdy  = ~empty & head_rdy;
    assign m0_rsp_vld = s_rsp_vld & ~empty & ~head;
    assign m1_rsp_vld = s_rsp_vld & ~empty &  head;
    assign m0_rsp_ir  = s_rsp_ir;
    assign m1_rsp_ir  = s_rsp_ir;
    assign rsp_hsk    = s_rsp_vld & s_rsp_rdy;

    assign idle = empty & ~lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else if (req_hsk) begin
            rr_last <= gnt;
            lock    <= 1'b0;
        end else if (s_req_vld) begin
            lock    <= 1'b1;
            lock_id <= gnt;
        end
    end

    // Push is gated by full at the start of the cycle, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ot_cnt  <= '0;
        end else begin
            if (req_hsk) begin
                id_fifo[wr_ptr] <= gnt;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (rsp_hsk) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({req_hsk, rsp_hsk})
                2'b10:   ot_cnt <= ot_cnt + CNT_W'(1);
                2'b01:   ot_cnt <= ot_cnt - CNT_W'(1);
                default: ot_cnt <= ot_cnt;
            endcase
        end
    end

    a_rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(s_rsp_vld && empty));

    a_locked_vld_held: assert property (@(posedge clk) disable iff (!rst_n)
        lock |-> (lock_id ? m1_req_vld : m0_req_vld));

    a_locked_pc_stable: assert property (@(posedge clk) disable iff (!rst_n)
        lock |-> $stable(s_req_pc));

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ot_cnt <= CNT_FULL);

endmodule

// File: tb/tb_fch_arb.sv
// Bench for fch_arb: queue-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with a mid-run reset.
module tb_fch_arb;
    localparam int PC_W     = 32;
    localparam int IR_W     = 32;
    localparam int OT_DEPTH = 2;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            m0_req_vld = 1'b0;
    logic            m0_req_rdy;
    logic [PC_W-1:0] m0_req_pc  = 32'h0000_1234;
    logic            m0_rsp_vld;
    logic            m0_rsp_rdy = 1'b0;
    logic [IR_W-1:0] m0_rsp_ir;
    logic            m1_req_vld = 1'b0;
    logic            m1_req_rdy;
    logic [PC_W-1:0] m1_req_pc  = 32'h0000_5678;
    logic            m1_rsp_vld;
    logic            m1_rsp_rdy = 1'b0;
    logic [IR_W-1:0] m1_rsp_ir;
    logic            s_req_vld;
    logic            s_req_rdy  = 1'b0;
    logic [PC_W-1:0] s_req_pc;
    logic            s_rsp_vld  = 1'b0;
    logic            s_rsp_rdy;
    logic [IR_W-1:0] s_rsp_ir   = '0;
    logic            idle;

    fch_arb #(.PC_W(PC_W), .IR_W(IR_W), .OT_DEPTH(OT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_pc(m0_req_pc),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_ir(m0_rsp_ir),
        .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_pc(m1_req_pc),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_ir(m1_rsp_ir),
        .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_pc(s_req_pc),
        .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_ir(s_rsp_ir),
        .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The slave answers each fetch with an instruction derived from its address.
    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'h4000_0013;
    endfunction

    // Reference model: list of owners of outstanding requests, last served master,
    // and the master whose request is waiting on a stalled slave.
    bit          own_q[$];
    logic [31:0] exp_ir0[$];
    logic [31:0] exp_ir1[$];
    bit          last_m    = 1'b1;
    bit          waiting   = 1'b0;
    bit          waiting_m = 1'b0;
    bit          e_req_hsk = 1'b0;
    bit          e_rsp_hsk = 1'b0;
    bit          e_gnt     = 1'b0;

    always @(negedge clk) begin
        bit          full, empty, gnt, head, ev, hr, rq, rs;
        logic [31:0] epc, want;
        if (!rst_n) begin
            own_q.delete();
            exp_ir0.delete();
            exp_ir1.delete();
            last_m  = 1'b1;
            waiting = 1'b0;
        end
        full  = (own_q.size() == OT_DEPTH);
        empty = (own_q.size() == 0);
        if (waiting)                        gnt = waiting_m;
        else if (m0_req_vld && m1_req_vld)  gnt = (last_m == 1'b0);
        else                                gnt = m1_req_vld;
        head = empty ? 1'b0 : own_q[0];
        ev   = (m0_req_vld || m1_req_vld) && !full;
        epc  = gnt ? m1_req_pc : m0_req_pc;
        hr   = head ? m1_rsp_rdy : m0_rsp_rdy;

        chk("s_req_vld",  32'(s_req_vld),  32'(ev));
        chk("s_req_pc",   s_req_pc,        epc);
        chk("m0_req_rdy", 32'(m0_req_rdy), 32'(!gnt && s_req_rdy && !full && m0_req_vld));
        chk("m1_req_rdy", 32'(m1_req_rdy), 32'(gnt && s_req_rdy && !full && m1_req_vld));
        chk("m0_rsp_vld", 32'(m0_rsp_vld), 32'(s_rsp_vld && !empty && !head));
        chk("m1_rsp_vld", 32'(m1_rsp_vld), 32'(s_rsp_vld && !empty && head));
        chk("s_rsp_rdy",  32'(s_rsp_rdy),  32'(!empty && hr));
        chk("idle",       32'(idle),       32'(empty && !waiting));
        if (s_rsp_vld && !empty && !head) chk("m0_rsp_ir", m0_rsp_ir, s_rsp_ir);
        if (s_rsp_vld && !empty && head)  chk("m1_rsp_ir", m1_rsp_ir, s_rsp_ir);

        if (rst_n) begin
            rq = ev && s_req_rdy;
            rs = s_rsp_vld && !empty && hr;
            if (rs) begin
                if (head) begin
                    want = exp_ir1.pop_front();
                    chk("m1_rsp_order", m1_rsp_ir, want);
                end else begin
                    want = exp_ir0.pop_front();
                    chk("m0_rsp_order", m0_rsp_ir, want);
                end
                own_q.delete(0);
            end
            if (rq) begin
                own_q.push_back(gnt);
                if (gnt) exp_ir1.push_back(ir_of(epc));
                else     exp_ir0.push_back(ir_of(epc));
                last_m  = gnt;
                waiting = 1'b0;
            end else if (ev) begin
                waiting   = 1'b1;
                waiting_m = gnt;
            end
            e_req_hsk = rq;
            e_rsp_hsk = rs;
            e_gnt     = gnt;
        end else begin
            e_req_hsk = 1'b0;
            e_rsp_hsk = 1'b0;
        end
    end

    // Stimulus: requesters hold vld/pc until accepted; the slave holds a response until taken.
    int          p_r0 = 0, p_r1 = 0, p_srdy = 0, p_svld = 0, p_rr0 = 0, p_rr1 = 0;
    bit          fix0 = 1'b0, fix1 = 1'b0;
    logic [31:0] pc0_fix = '0, pc1_fix = '0;
    bit          act0 = 1'b0, act1 = 1'b0, svld_hold = 1'b0;
    logic [31:0] slave_q[$];

    function automatic bit roll(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (e_rsp_hsk) begin
            slave_q.delete(0);
            svld_hold = 1'b0;
        end
        if (e_req_hsk) begin
            slave_q.push_back(e_gnt ? m1_req_pc : m0_req_pc);
            if (e_gnt) act1 = 1'b0;
            else       act0 = 1'b0;
        end
        if (!act0 && roll(p_r0)) begin
            act0      = 1'b1;
            m0_req_pc = fix0 ? pc0_fix : $urandom;
        end
        if (!act1 && roll(p_r1)) begin
            act1      = 1'b1;
            m1_req_pc = fix1 ? pc1_fix : $urandom;
        end
        m0_req_vld = act0;
        m1_req_vld = act1;
        s_req_rdy  = roll(p_srdy);
        if (!svld_hold && slave_q.size() > 0 && roll(p_svld)) svld_hold = 1'b1;
        s_rsp_vld  = svld_hold;
        s_rsp_ir   = svld_hold ? ir_of(slave_q[0]) : $urandom;
        m0_rsp_rdy = roll(p_rr0);
        m1_rsp_rdy = roll(p_rr1);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        act0       = 1'b0;
        act1       = 1'b0;
        svld_hold  = 1'b0;
        slave_q.delete();
        m0_req_vld = 1'b0;
        m1_req_vld = 1'b0;
        s_req_rdy  = 1'b0;
        s_rsp_vld  = 1'b0;
        m0_rsp_rdy = 1'b0;
        m1_rsp_rdy = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        p_r0 = 0; p_r1 = 0; p_srdy = 100; p_svld = 100; p_rr0 = 100; p_rr1 = 100;
        n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
        end while (!(idle === 1'b1 && slave_q.size() == 0 && !act0 && !act1) && n < 60);
        chk(name, 32'(idle === 1'b1 && slave_q.size() == 0 && !act0 && !act1), 32'd1);
    endtask

    task automatic lit_quiet(input string tag);
        chk({tag, "_s_req_vld"},  32'(s_req_vld),  32'd0);
        chk({tag, "_m0_req_rdy"}, 32'(m0_req_rdy), 32'd0);
        chk({tag, "_m1_req_rdy"}, 32'(m1_req_rdy), 32'd0);
        chk({tag, "_m0_rsp_vld"}, 32'(m0_rsp_vld), 32'd0);
        chk({tag, "_m1_rsp_vld"}, 32'(m1_rsp_vld), 32'd0);
        chk({tag, "_s_rsp_rdy"},  32'(s_rsp_rdy),  32'd0);
        chk({tag, "_idle"},       32'(idle),       32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int alt_exp[4];
        int g;
        alt_exp = '{1, 0, 1, 0};

        // Reset state
        repeat (2) @(negedge clk);
        lit_quiet("lit_rst");
        chk("lit_rst_s_req_pc", s_req_pc, 32'h0000_1234);
        release_reset();

        // Solo m0, zero-latency acceptance, response routed to m0 only
        p_r0 = 100; fix0 = 1'b1; pc0_fix = 32'h4000_0000; p_srdy = 100; p_rr0 = 100; p_rr1 = 100;
        tick();
        p_r0 = 0;
        @(negedge clk);
        chk("lit_solo_s_req_vld",  32'(s_req_vld),  32'd1);
        chk("lit_solo_s_req_pc",   s_req_pc,        32'h4000_0000);
        chk("lit_solo_m0_req_rdy", 32'(m0_req_rdy), 32'd1);
        chk("lit_solo_m1_req_rdy", 32'(m1_req_rdy), 32'd0);
        p_svld = 100;
        tick();
        @(negedge clk);
        chk("lit_solo_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
        chk("lit_solo_m1_rsp_vld", 32'(m1_rsp_vld), 32'd0);
        chk("lit_solo_m0_rsp_ir",  m0_rsp_ir,       32'h0000_0013);
        chk("lit_solo_s_rsp_rdy",  32'(s_rsp_rdy),  32'd1);
        drain("drain_solo");

        // Both requesting every cycle: grants alternate, m1 first since m0 was served last
        fix0 = 1'b0; fix1 = 1'b0;
        p_r0 = 100; p_r1 = 100; p_srdy = 100; p_svld = 100; p_rr0 = 100; p_rr1 = 100;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            g = m1_req_rdy ? 1 : (m0_req_rdy ? 0 : 2);
            chk("lit_alt_gnt", g, alt_exp[i]);
        end
        drain("drain_alt");

        // m1 stalled for three cycles; m0 arrives and must wait behind the held grant
        p_svld = 0; p_srdy = 0; p_r0 = 0; p_r1 = 100; fix1 = 1'b1; pc1_fix = 32'h0000_2000;
        tick();
        @(negedge clk);
        chk("lit_stall_a_vld", 32'(s_req_vld),  32'd1);
        chk("lit_stall_a_pc",  s_req_pc,        32'h0000_2000);
        chk("lit_stall_a_rdy", 32'(m1_req_rdy), 32'd0);
        p_r0 = 100; fix0 = 1'b1; pc0_fix = 32'h0000_1000; p_r1 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("lit_stall_pc",     s_req_pc,        32'h0000_2000);
            chk("lit_stall_m0_rdy", 32'(m0_req_rdy), 32'd0);
            chk("lit_stall_idle",   32'(idle),       32'd0);
        end
        p_srdy = 100;
        tick();
        p_r0 = 0;
        @(negedge clk);
        chk("lit_stall_rel_m1_rdy", 32'(m1_req_rdy), 32'd1);
        chk("lit_stall_rel_m0_rdy", 32'(m0_req_rdy), 32'd0);
        chk("lit_stall_rel_pc",     s_req_pc,        32'h0000_2000);
        tick();
        @(negedge clk);
        chk("lit_stall_next_m0_rdy", 32'(m0_req_rdy), 32'd1);
        chk("lit_stall_next_pc",     s_req_pc,        32'h0000_1000);

        // Two outstanding: third request blocked until a response frees a slot
        p_r1 = 100; pc1_fix = 32'h0000_3000;
        tick();
        @(negedge clk);
        chk("lit_full_s_req_vld", 32'(s_req_vld),  32'd0);
        chk("lit_full_m1_rdy",    32'(m1_req_rdy), 32'd0);
        p_svld = 100; p_rr0 = 100; p_rr1 = 100;
        tick();
        @(negedge clk);
        chk("lit_full_pop_m1_rdy",  32'(m1_req_rdy), 32'd0);
        chk("lit_full_pop_rsp_vld", 32'(m1_rsp_vld), 32'd1);
        chk("lit_full_pop_rsp_ir",  m1_rsp_ir,       32'h4000_2013);
        p_svld = 0;
        tick();
        p_r1 = 0;
        @(negedge clk);
        chk("lit_full_after_m1_rdy", 32'(m1_req_rdy), 32'd1);
        chk("lit_full_after_pc",     s_req_pc,        32'h0000_3000);

        // Head response for m1 held off by m1; m0 must not see it
        p_svld = 100; p_rr0 = 100; p_rr1 = 0;
        tick();
        @(negedge clk);
        chk("lit_head_m0_rsp_vld", 32'(m0_rsp_vld), 32'd1);
        chk("lit_head_m0_rsp_ir",  m0_rsp_ir,       32'h4000_1013);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("lit_head_blk_s_rsp_rdy", 32'(s_rsp_rdy),  32'd0);
            chk("lit_head_blk_m1_vld",    32'(m1_rsp_vld), 32'd1);
            chk("lit_head_blk_m0_vld",    32'(m0_rsp_vld), 32'd0);
        end
        p_rr1 = 100;
        tick();
        p_svld = 0;
        @(negedge clk);
        chk("lit_head_rel_s_rsp_rdy", 32'(s_rsp_rdy), 32'd1);
        chk("lit_head_rel_m1_ir",     m1_rsp_ir,      32'h4000_3013);
        tick();
        @(negedge clk);
        chk("lit_head_done_idle", 32'(idle), 32'd1);

        // Reset with two requests outstanding
        fix0 = 1'b0; p_r0 = 100; p_r1 = 0; p_srdy = 100; p_svld = 0;
        tick();
        tick();
        @(negedge clk);
        chk("lit_mid_busy_idle", 32'(idle), 32'd0);
        assert_reset();
        @(negedge clk);
        lit_quiet("lit_mid_rst");
        release_reset();
        @(negedge clk);
        lit_quiet("lit_mid_after");

        // Randomized traffic with varying pressure and one reset mid-stream
        for (int seg = 0; seg < 10; seg++) begin
            p_r0   = int'($urandom_range(100, 10));
            p_r1   = int'($urandom_range(100, 10));
            p_srdy = int'($urandom_range(100, 20));
            p_svld = int'($urandom_range(100, 20));
            p_rr0  = int'($urandom_range(100, 20));
            p_rr1  = int'($urandom_range(100, 20));
            for (int i = 0; i < 300; i++) tick();
            if (seg == 5) begin
                assert_reset();
                repeat (2) @(posedge clk);
                release_reset();
            end
        end
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
